// File: rtl/cnn_pkg.sv
// Shared constants, word type and pooling FSM encoding for the CNN accelerator.
package cnn_pkg;
    localparam int DATA_W    = 16;
    localparam int MAX_BLOCK = 1024;
    localparam int SUM_W     = 20;

    typedef logic signed [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {IDLE, LOAD, POOL, NEXT, DONE} pool_state_t;

    // Window sizes other than 1, 2 and 4 behave as 2x2.
    function automatic logic [1:0] windowShift(input logic [DATA_W-1:0] ws);
        case (ws)
            16'd1:   return 2'd0;
            16'd4:   return 2'd2;
            default: return 2'd1;
        endcase
    endfunction
endpackage

// File: rtl/pool_layer_unit_if.sv
// Load-block and memory-write signals shared by the pooling controller and its peers.
interface pool_layer_unit_if
#(
    parameter int DATA_W    = cnn_pkg::DATA_W,
    parameter int MAX_BLOCK = cnn_pkg::MAX_BLOCK
);
    logic                     loadEnable;
    logic        [DATA_W-1:0] loadAddr;
    logic        [DATA_W-1:0] loadSize;
    logic                     loadDone;
    logic signed [DATA_W-1:0] loadOut [MAX_BLOCK];
    logic        [DATA_W-1:0] blockAddr;
    logic        [DATA_W-1:0] writeAddr;
    logic        [DATA_W-1:0] writeOut;
    logic                     writeEnable;
    logic        [DATA_W-1:0] memAddr;
    logic                     memWe;

    modport master (
        output loadEnable, loadAddr, loadSize, writeAddr, writeOut, writeEnable, memAddr, memWe,
        input  loadDone, loadOut, blockAddr
    );

    modport slave (
        input  loadEnable, loadAddr, loadSize, writeAddr, writeOut, writeEnable, memAddr, memWe,
        output loadDone, loadOut, blockAddr
    );
endinterface

// File: rtl/pool_window_avg.sv
// Combinational ws x ws window sum over the loaded block, scaled by an arithmetic shift to a floor average.
module pool_window_avg
#(
    parameter int DATA_W    = cnn_pkg::DATA_W,
    parameter int MAX_BLOCK = cnn_pkg::MAX_BLOCK
)
(
    input  logic signed [DATA_W-1:0] loadOut [MAX_BLOCK],
    input  logic        [DATA_W-1:0] r,
    input  logic        [DATA_W-1:0] c,
    input  logic        [DATA_W-1:0] imgSize,
    input  logic        [DATA_W-1:0] ws,
    input  logic        [1:0]        shiftS,
    output logic signed [DATA_W-1:0] avg
);
    import cnn_pkg::*;

    localparam int IDX_W = $clog2(MAX_BLOCK);

    logic signed [SUM_W-1:0] sum;
    int                      idx;

    // Fixed 4x4 scan; taps outside the active window are masked off.
    always_comb begin
        sum = '0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                idx = (int'(r) * int'(ws) + i) * int'(imgSize) + int'(c) * int'(ws) + j;
                if (i < int'(ws) && j < int'(ws) && idx >= 0 && idx < MAX_BLOCK)
                    sum = sum + SUM_W'(loadOut[IDX_W'(idx)]);
            end
        end
    end

    assign avg = DATA_W'(sum >>> {shiftS, 1'b0});
endmodule

// File: rtl/pool_layer_unit.sv
// Average-pooling controller: loads each map of a batch, then streams its pooled words back to memory.
// IDLE: wait for enable | LOAD: block load requested | POOL: one pooled write per cycle | NEXT: advance map | DONE: batch complete
module pool_layer_unit
#(
    parameter int DATA_W    = cnn_pkg::DATA_W,
    parameter int MAX_BLOCK = cnn_pkg::MAX_BLOCK
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] imgsNumber,
    input  logic [DATA_W-1:0] imgSize,
    input  logic [DATA_W-1:0] imgsAddress,
    input  logic [DATA_W-1:0] windowSize,
    output logic              done,
    pool_layer_unit_if.master bus
);
    import cnn_pkg::*;

    pool_state_t       state, nextState;

    logic [DATA_W-1:0] img, imgNext;
    logic [DATA_W-1:0] row, rowNext;
    logic [DATA_W-1:0] col, colNext;
    logic [DATA_W-1:0] numImgs, numImgsNext;
    logic [DATA_W-1:0] side, sideNext;
    logic [DATA_W-1:0] winSize, winSizeNext;
    logic [DATA_W-1:0] dSide, dSideNext;
    logic [DATA_W-1:0] blockWords, blockWordsNext;
    logic [DATA_W-1:0] wrPtr, wrPtrNext;
    logic [1:0]        shiftS, shiftSNext;

    logic [DATA_W-1:0] loadAddrQ, loadAddrNext;
    logic [DATA_W-1:0] loadSizeQ, loadSizeNext;
    logic [DATA_W-1:0] writeAddrQ, writeAddrNext;
    logic [DATA_W-1:0] writeOutQ, writeOutNext;
    logic              writeEnableQ, writeEnableNext;
    logic              loadEnableQ, loadEnableNext;
    logic              doneQ, doneNext;

    logic [1:0]        shiftIn;
    logic [DATA_W-1:0] wordsIn;
    word_t             avg;

    assign shiftIn = windowShift(windowSize);
    assign wordsIn = imgSize * imgSize;

    pool_window_avg #(.DATA_W(DATA_W), .MAX_BLOCK(MAX_BLOCK)) u_avg (
        .loadOut (bus.loadOut),
        .r       (row),
        .c       (col),
        .imgSize (side),
        .ws      (winSize),
        .shiftS  (shiftS),
        .avg     (avg)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState       = state;
        imgNext         = img;
        rowNext         = row;
        colNext         = col;
        numImgsNext     = numImgs;
        sideNext        = side;
        winSizeNext     = winSize;
        dSideNext       = dSide;
        blockWordsNext  = blockWords;
        wrPtrNext       = wrPtr;
        shiftSNext      = shiftS;
        loadAddrNext    = loadAddrQ;
        loadSizeNext    = loadSizeQ;
        writeAddrNext   = writeAddrQ;
        writeOutNext    = writeOutQ;
        writeEnableNext = 1'b0;
        loadEnableNext  = 1'b0;
        doneNext        = 1'b0;

        // Dropping enable wins in every state; strobes are already defaulted low.
        if (!enable) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    numImgsNext    = imgsNumber;
                    sideNext       = imgSize;
                    shiftSNext     = shiftIn;
                    winSizeNext    = DATA_W'(1) << shiftIn;
                    dSideNext      = imgSize >> shiftIn;
                    blockWordsNext = wordsIn;
                    wrPtrNext      = imgsAddress + imgsNumber * wordsIn;
                    imgNext        = '0;
                    if (imgsNumber == '0) begin
                        nextState = DONE;
                        doneNext  = 1'b1;
                    end else begin
                        nextState      = LOAD;
                        loadEnableNext = 1'b1;
                        loadAddrNext   = imgsAddress;
                        loadSizeNext   = wordsIn;
                    end
                end
                LOAD: begin
                    loadEnableNext = 1'b1;
                    if (bus.loadDone) begin
                        nextState      = POOL;
                        loadEnableNext = 1'b0;
                        rowNext        = '0;
                        colNext        = '0;
                    end
                end
                POOL: begin
                    if (dSide == '0) begin
                        nextState = NEXT;
                    end else begin
                        writeEnableNext = 1'b1;
                        writeOutNext    = avg;
                        writeAddrNext   = wrPtr;
                        wrPtrNext       = wrPtr + 1'b1;
                        if (col == dSide - 1'b1) begin
                            colNext = '0;
                            if (row == dSide - 1'b1) nextState = NEXT;
                            else                     rowNext   = row + 1'b1;
                        end else begin
                            colNext = col + 1'b1;
                        end
                    end
                end
                NEXT: begin
                    imgNext = img + 1'b1;
                    if (img + 1'b1 == numImgs) begin
                        nextState = DONE;
                        doneNext  = 1'b1;
                    end else begin
                        nextState      = LOAD;
                        loadEnableNext = 1'b1;
                        loadAddrNext   = loadAddrQ + blockWords;
                    end
                end
                DONE: begin
                    doneNext = 1'b1;
                end
                default: begin
                    nextState = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            img          <= '0;
            row          <= '0;
            col          <= '0;
            numImgs      <= '0;
            side         <= '0;
            winSize      <= '0;
            dSide        <= '0;
            blockWords   <= '0;
            wrPtr        <= '0;
            shiftS       <= '0;
            loadAddrQ    <= '0;
            loadSizeQ    <= '0;
            writeAddrQ   <= '0;
            writeOutQ    <= '0;
            writeEnableQ <= 1'b0;
            loadEnableQ  <= 1'b0;
            doneQ        <= 1'b0;
        end else begin
            img          <= imgNext;
            row          <= rowNext;
            col          <= colNext;
            numImgs      <= numImgsNext;
            side         <= sideNext;
            winSize      <= winSizeNext;
            dSide        <= dSideNext;
            blockWords   <= blockWordsNext;
            wrPtr        <= wrPtrNext;
            shiftS       <= shiftSNext;
            loadAddrQ    <= loadAddrNext;
            loadSizeQ    <= loadSizeNext;
            writeAddrQ   <= writeAddrNext;
            writeOutQ    <= writeOutNext;
            writeEnableQ <= writeEnableNext;
            loadEnableQ  <= loadEnableNext;
            doneQ        <= doneNext;
        end
    end

    assign bus.loadEnable  = loadEnableQ;
    assign bus.loadAddr    = loadAddrQ;
    assign bus.loadSize    = loadSizeQ;
    assign bus.writeAddr   = writeAddrQ;
    assign bus.writeOut    = writeOutQ;
    assign bus.writeEnable = writeEnableQ;
    assign done            = doneQ;

    // Shared memory port: our writes take the address bus, otherwise the load block reads through it.
    assign bus.memAddr = writeEnableQ ? writeAddrQ : bus.blockAddr;
    assign bus.memWe   = writeEnableQ;
endmodule

// File: tb/tb_pool_layer_unit.sv
// Bench for pool_layer_unit: table vectors, corner sequences and randomized batches against an arithmetic model.
module tb_pool_layer_unit;
    logic        clk = 1'b0;
    logic        reset, enable, done;
    logic [15:0] imgsNumber, imgSize, imgsAddress, windowSize;

    pool_layer_unit_if bus ();

    pool_layer_unit dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .imgsNumber  (imgsNumber),
        .imgSize     (imgSize),
        .imgsAddress (imgsAddress),
        .windowSize  (windowSize),
        .done        (done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int loadLat = 0;
    int leSeen = 0;
    int doneCyc = -1;
    logic [15:0] mem [65536];
    int wrAddr[$], wrData[$], wrCyc[$], expA[$], expD[$];

    typedef struct {
        int n; int sz; int addr; int ws; int fill;
        int expN; int expBase; int v [4];
    } vec_t;
    vec_t vecs [7];

    function automatic vec_t mkVec(input int n, input int sz, input int addr, input int ws, input int fill,
                                   input int expN, input int expBase, input int v0, input int v1, input int v2, input int v3);
        vec_t x;
        x.n = n; x.sz = sz; x.addr = addr; x.ws = ws; x.fill = fill;
        x.expN = expN; x.expBase = expBase;
        x.v[0] = v0; x.v[1] = v1; x.v[2] = v2; x.v[3] = v3;
        return x;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Load block: after loadLat idle cycles copies the requested block and pulses loadDone.
    initial begin
        int cnt;
        cnt = 0;
        bus.loadDone  = 1'b0;
        bus.blockAddr = 16'h0ABC;
        for (int k = 0; k < 1024; k++) bus.loadOut[k] = '0;
        forever begin
            @(negedge clk);
            if (bus.loadEnable === 1'b1 && bus.loadDone === 1'b0) begin
                if (cnt >= loadLat) begin
                    for (int k = 0; k < int'(bus.loadSize) && k < 1024; k++)
                        bus.loadOut[k] = mem[16'(int'(bus.loadAddr) + k)];
                    bus.loadDone = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                bus.loadDone = 1'b0;
                cnt = 0;
            end
        end
    end

    // Memory write port and write log.
    initial forever begin
        @(negedge clk);
        if (bus.memWe === 1'b1) begin
            mem[bus.memAddr] = bus.writeOut;
            wrAddr.push_back(int'(bus.memAddr));
            wrData.push_back(int'($signed(bus.writeOut)));
            wrCyc.push_back(cyc);
        end
        if (bus.loadEnable === 1'b1) leSeen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic int floorDiv(input int s, input int dv);
        int q;
        q = s / dv;
        if (s % dv != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic fillMaps(input int n, input int sz, input int addr, input int fill);
        for (int m = 0; m < n; m++)
            for (int k = 0; k < sz * sz; k++)
                mem[16'(addr + m * sz * sz + k)] = (fill != 0) ? 16'(-(k + 1)) : 16'(k);
    endtask

    // Reference: pooled floor averages per map in raster order, stored right after the batch.
    task automatic modelRun(input int n, input int sz, input int addr, input int wsIn);
        int w, d, nw, k, sum;
        w  = (wsIn == 1 || wsIn == 2 || wsIn == 4) ? wsIn : 2;
        d  = sz / w;
        nw = sz * sz;
        k  = 0;
        expA.delete();
        expD.delete();
        for (int m = 0; m < n; m++)
            for (int r = 0; r < d; r++)
                for (int c = 0; c < d; c++) begin
                    sum = 0;
                    for (int i = 0; i < w; i++)
                        for (int j = 0; j < w; j++)
                            sum += int'($signed(mem[16'(addr + m * nw + (r * w + i) * sz + c * w + j)]));
                    expA.push_back((addr + n * nw + k) % 65536);
                    expD.push_back(int'($signed(16'(floorDiv(sum, w * w)))));
                    k++;
                end
    endtask

    task automatic startRun(input int n, input int sz, input int addr, input int ws);
        @(negedge clk);
        imgsNumber  = 16'(n);
        imgSize     = 16'(sz);
        imgsAddress = 16'(addr);
        windowSize  = 16'(ws);
        wrAddr.delete(); wrData.delete(); wrCyc.delete();
        leSeen  = 0;
        doneCyc = -1;
        enable  = 1'b1;
    endtask

    task automatic waitDone(input string name);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({name, " done reached"}, {31'd0, done}, 32'd1);
        doneCyc = cyc;
    endtask

    task automatic stopRun(input string name);
        enable = 1'b0;
        @(negedge clk);
        check({name, " done cleared"}, {31'd0, done}, 32'd0);
    endtask

    task automatic compareWrites(input string name);
        check({name, " write count"}, wrAddr.size(), expA.size());
        for (int k = 0; k < wrAddr.size() && k < expA.size(); k++) begin
            check($sformatf("%s addr[%0d]", name, k), wrAddr[k], expA[k]);
            check($sformatf("%s data[%0d]", name, k), wrData[k], expD[k]);
        end
        if (expA.size() > 0 && wrCyc.size() > 0)
            check({name, " done after last write"}, doneCyc - wrCyc[$], 32'd1);
    endtask

    initial begin
        int n1, t, n, sz, addr, ws;

        vecs[0] = mkVec(3, 4,   0, 2, 0, 12,  48,  2,  4, 10, 12);
        vecs[1] = mkVec(1, 2,   0, 2, 1,  1,   4, -3,  0,  0,  0);
        vecs[2] = mkVec(1, 8,   0, 4, 0,  4,  64, 13, 17, 45, 49);
        vecs[3] = mkVec(1, 4, 100, 3, 0,  4, 116,  2,  4, 10, 12);
        vecs[4] = mkVec(1, 2,   0, 1, 0,  4,   4,  0,  1,  2,  3);
        vecs[5] = mkVec(1, 3,   0, 2, 0,  1,   9,  2,  0,  0,  0);
        vecs[6] = mkVec(2, 1,   0, 2, 0,  0,   2,  0,  0,  0,  0);

        reset = 1'b1; enable = 1'b0;
        imgsNumber = '0; imgSize = '0; imgsAddress = '0; windowSize = '0;
        repeat (3) @(negedge clk);
        check("reset loadAddr",    bus.loadAddr,    0);
        check("reset loadSize",    bus.loadSize,    0);
        check("reset writeAddr",   bus.writeAddr,   0);
        check("reset writeOut",    bus.writeOut,    0);
        check("reset writeEnable", bus.writeEnable, 0);
        check("reset loadEnable",  bus.loadEnable,  0);
        check("reset done",        done,            0);
        check("idle memAddr mux",  bus.memAddr,     32'h0ABC);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fillMaps(vecs[v].n, vecs[v].sz, vecs[v].addr, vecs[v].fill);
            loadLat = v % 3;
            expA.delete(); expD.delete();
            for (int k = 0; k < vecs[v].expN; k++) begin
                expA.push_back(vecs[v].expBase + k);
                expD.push_back(vecs[v].v[k % 4]);
            end
            startRun(vecs[v].n, vecs[v].sz, vecs[v].addr, vecs[v].ws);
            waitDone($sformatf("vec%0d", v));
            compareWrites($sformatf("vec%0d", v));
            check($sformatf("vec%0d loadSize", v), bus.loadSize, vecs[v].sz * vecs[v].sz);
            stopRun($sformatf("vec%0d", v));
        end

        // Empty batch: done on the next cycle, no bus activity.
        loadLat = 0;
        startRun(0, 4, 0, 2);
        @(negedge clk);
        check("empty done", {31'd0, done}, 32'd1);
        check("empty no loadEnable", leSeen, 0);
        check("empty no writes", wrAddr.size(), 0);
        stopRun("empty");

        // Abort inside the second map's POOL, then restart from map 0.
        fillMaps(2, 4, 300, 0);
        modelRun(2, 4, 300, 1);
        loadLat = 1;
        startRun(2, 4, 300, 1);
        t = 0;
        while (wrAddr.size() < 20 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("abort reached map1", {31'd0, wrAddr.size() >= 20}, 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("abort writeEnable", bus.writeEnable, 0);
        check("abort loadEnable",  bus.loadEnable,  0);
        check("abort done",        done,            0);
        n1 = wrAddr.size();
        repeat (6) @(negedge clk);
        check("abort no more writes", wrAddr.size(), n1);
        check("abort partial", {31'd0, n1 < 32}, 32'd1);
        startRun(2, 4, 300, 1);
        @(negedge clk);
        check("restart loadAddr",   bus.loadAddr,   300);
        check("restart loadEnable", bus.loadEnable, 1);
        waitDone("restart");
        compareWrites("restart");
        stopRun("restart");

        // Reset while waiting on a slow load.
        fillMaps(1, 4, 500, 0);
        loadLat = 30;
        startRun(1, 4, 500, 2);
        repeat (3) @(negedge clk);
        check("rstload loadEnable before", bus.loadEnable, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstload loadAddr",    bus.loadAddr,    0);
        check("rstload loadSize",    bus.loadSize,    0);
        check("rstload writeAddr",   bus.writeAddr,   0);
        check("rstload writeOut",    bus.writeOut,    0);
        check("rstload writeEnable", bus.writeEnable, 0);
        check("rstload loadEnable",  bus.loadEnable,  0);
        check("rstload done",        done,            0);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            n    = int'($urandom_range(1, 3));
            sz   = int'($urandom_range(1, 8));
            addr = int'($urandom_range(0, 400));
            ws   = int'($urandom_range(1, 4));
            loadLat = int'($urandom_range(0, 3));
            for (int k = 0; k < n * sz * sz; k++) mem[16'(addr + k)] = 16'($urandom);
            modelRun(n, sz, addr, ws);
            startRun(n, sz, addr, ws);
            waitDone($sformatf("rand%0d", r));
            compareWrites($sformatf("rand%0d", r));
            stopRun($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
